// File: rtl/rng_pkg.sv
// Shared definitions for RNG post-processors: the sampler FSM state type
// and a helper that builds the rejection-sampling mask for a bound N.
`ifndef RNG_PKG_SV
`define RNG_PKG_SV

package rng_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2
  } rng_state_e;

  // Smallest 2^k-1 that covers N-1; N=1 (and N=0) yield 0.
  function automatic logic [31:0] range_mask(input logic [31:0] n);
    logic [31:0] m;
    m = (n == 32'd0) ? 32'd0 : n - 32'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

`endif

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush. Pointers wrap modulo DEPTH (power of
// two); a separate occupancy count tells full from empty. A push while full
// only lands when a pop happens in the same cycle, otherwise it is dropped.
// dout reads as zero while empty so the output is defined out of reset.
`ifndef SYNC_FIFO_SV
`define SYNC_FIFO_SV

module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage write; contents are don't-care until counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; flush empties the buffer in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`endif

// File: rtl/range_sampler.sv
// Rejection sampler: maps raw 32-bit random words onto [0, N) by masking
// the low OUT_W bits to the smallest covering 2^k-1 and discarding values
// >= N. Accepted samples are buffered in a sync_fifo.
// Optional macro RANGE_SAMPLER_STATS_EN adds saturating reject/drop counters.
// Handshake: a sample transfers on a rising edge where out_valid and
// out_ready are both 1; out_data holds steady while out_valid=1 and
// out_ready=0. Upstream words are never back-pressured: when the buffer is
// full and not popping, accepted samples are dropped.
`ifndef RANGE_SAMPLER_SV
`define RANGE_SAMPLER_SV

module range_sampler
  import rng_pkg::*;
#(
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      rnd_in,
  input  logic             rnd_valid,
  input  logic             cfg_we,
  input  logic [OUT_W-1:0] range_n,
  output logic             cfg_err,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output rng_state_e       state_dbg
`ifdef RANGE_SAMPLER_STATS_EN
  ,
  output logic [31:0]      rej_count,
  output logic [31:0]      drop_count
`endif
);

  rng_state_e       state;
  rng_state_e       state_next;
  logic [OUT_W-1:0] n_reg;
  logic [OUT_W-1:0] mask_reg;
  logic [31:0]      mask_full;
  logic [OUT_W-1:0] cand;
  logic             accept;
  logic             start_setup;
  logic             sample_req;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic             unused_bits;

  // A nonzero bound reconfigures from IDLE or RUN; SETUP is a fixed one-cycle gap.
  assign start_setup = cfg_we && (range_n != '0) && (state != SETUP);
  assign mask_full   = range_mask(32'(range_n));
  assign cand        = rnd_in[OUT_W-1:0] & mask_reg;
  assign accept      = (cand < n_reg);
  assign sample_req  = (state == RUN) && rnd_valid && !start_setup;
  assign push        = sample_req && accept;
  assign pop         = out_valid && out_ready;
  assign out_valid   = !fifo_empty;
  assign state_dbg   = state;
  assign unused_bits = ^{rnd_in, mask_full};

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE:    if (start_setup) state_next = SETUP;
      SETUP: begin
        busy       = 1'b1;
        state_next = RUN;
      end
      RUN:     if (start_setup) state_next = SETUP;
      default: state_next = IDLE;
    endcase
  end

  // Bound and mask captured as SETUP is entered; a zero bound only raises cfg_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reg    <= '0;
      mask_reg <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= cfg_we && (range_n == '0);
      if (start_setup) begin
        n_reg    <= range_n;
        mask_reg <= mask_full[OUT_W-1:0];
      end
    end
  end

`ifdef RANGE_SAMPLER_STATS_EN
  // Saturating reject/drop counters, cleared on entry to SETUP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rej_count  <= '0;
      drop_count <= '0;
    end else if (start_setup) begin
      rej_count  <= '0;
      drop_count <= '0;
    end else begin
      if (sample_req && !accept && (rej_count != '1))
        rej_count <= rej_count + 32'd1;
      if (push && fifo_full && !pop && (drop_count != '1))
        drop_count <= drop_count + 32'd1;
    end
  end
`endif

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (start_setup),
    .push  (push),
    .pop   (pop),
    .din   (cand),
    .dout  (out_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

`endif

// File: tb/tb_range_sampler.sv
// Bench for range_sampler: behavioural model (bound, buffered sample queue)
// compared against the DUT every falling edge, plus directed literal checks.
module tb_range_sampler;
  import rng_pkg::*;

  localparam int OUT_W = 16;
  localparam int DEPTH = 4;
  localparam int M_IDLE  = 0;
  localparam int M_SETUP = 1;
  localparam int M_RUN   = 2;

  // Clock / reset / DUT signals
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      rnd_in = '0;
  logic             rnd_valid = 1'b0;
  logic             cfg_we = 1'b0;
  logic [OUT_W-1:0] range_n = '0;
  logic             cfg_err;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_ready = 1'b0;
  logic             busy;
  rng_state_e       state_dbg;
`ifdef RANGE_SAMPLER_STATS_EN
  logic [31:0]      rej_count;
  logic [31:0]      drop_count;
`endif

  always #5 clk = ~clk;

  range_sampler #(.OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rnd_in    (rnd_in),
    .rnd_valid (rnd_valid),
    .cfg_we    (cfg_we),
    .range_n   (range_n),
    .cfg_err   (cfg_err),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .state_dbg (state_dbg)
`ifdef RANGE_SAMPLER_STATS_EN
    ,
    .rej_count  (rej_count),
    .drop_count (drop_count)
`endif
  );

  // Scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  int               mode;
  int unsigned      n_m;
  int unsigned      mask_m;
  bit               err_m;
  int unsigned      rej_m;
  int unsigned      drop_m;
  logic [OUT_W-1:0] exp_q[$];
  bit               m_start;
  bit               m_pop;
  bit               m_push;
  int unsigned      m_cand;
  bit               seen[16];

  function automatic int unsigned model_mask(input int unsigned n);
    int unsigned m;
    m = 0;
    while (n > 0 && m < n - 1) m = m * 2 + 1;
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mode = M_IDLE; n_m = 0; mask_m = 0; err_m = 0; rej_m = 0; drop_m = 0;
      exp_q.delete();
    end else begin
      m_pop   = (exp_q.size() > 0) && out_ready;
      m_start = cfg_we && (range_n != 0) && (mode != M_SETUP);
      m_push  = 0;
      m_cand  = 0;
      if (mode == M_RUN && rnd_valid && !m_start) begin
        m_cand = (rnd_in % (32'd1 << OUT_W)) % (mask_m + 1);
        if (m_cand < n_m) begin
          if (exp_q.size() < DEPTH || m_pop) m_push = 1;
          else if (drop_m != 32'hFFFF_FFFF) drop_m++;
        end else if (rej_m != 32'hFFFF_FFFF) rej_m++;
      end
      if (m_pop)  void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(m_cand[OUT_W-1:0]);
      err_m = cfg_we && (range_n == 0);
      if (m_start) begin
        mode = M_SETUP; n_m = range_n; mask_m = model_mask(range_n);
        exp_q.delete(); rej_m = 0; drop_m = 0;
      end else if (mode == M_SETUP) mode = M_RUN;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    chk("out_valid", out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) chk("out_data", out_data, exp_q[0]);
    chk("busy", busy, mode == M_SETUP);
    chk("cfg_err", cfg_err, err_m);
`ifdef RANGE_SAMPLER_STATS_EN
    chk("rej_count", rej_count, rej_m);
    chk("drop_count", drop_count, drop_m);
`endif
  end

  // Driver: apply one cycle of inputs at a falling edge, return at the next.
  task automatic step(input bit we, input logic [OUT_W-1:0] n, input bit v,
                      input logic [31:0] r, input bit rdy);
    if (out_valid && rdy && out_data < 16) seen[out_data[3:0]] = 1;
    cfg_we = we; range_n = n; rnd_valid = v; rnd_in = r; out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic configure(input logic [OUT_W-1:0] n);
    step(1, n, 0, 0, 1);
    step(0, 0, 0, 0, 1);
  endtask

  initial begin
    logic [15:0] words [6];
    int cnt;
    words = '{16'd5, 16'd9, 16'd2, 16'd14, 16'd7, 16'd1};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_state", state_dbg, IDLE);
    rst = 0;

    // No auto-start from IDLE
    repeat (5) step(0, 0, 1, $urandom, 1);
    chk("idle_no_valid", out_valid, 0);

    // N=10: accept 3, reject 0xC
    step(1, 10, 0, 0, 1);
    chk("setup_busy", busy, 1);
    step(0, 0, 0, 0, 1);
    chk("run_busy", busy, 0);
    chk("run_state", state_dbg, RUN);
    step(0, 0, 1, 32'h1234_0003, 1);
    chk("n10_valid", out_valid, 1);
    chk("n10_data", out_data, 3);
    step(0, 0, 1, 32'h5678_000C, 1);
    chk("n10_reject_valid", out_valid, 0);
`ifdef RANGE_SAMPLER_STATS_EN
    chk("n10_rej_count", rej_count, 1);
`endif

    // N=16: no rejects, all values observed
    configure(16);
    for (int i = 0; i < 16; i++) seen[i] = 0;
    repeat (1000) step(0, 0, 1, $urandom, 1);
    cnt = 0;
    for (int i = 0; i < 16; i++) if (seen[i]) cnt++;
    chk("n16_seen", cnt, 16);
`ifdef RANGE_SAMPLER_STATS_EN
    chk("n16_rej", rej_count, 0);
`endif

    // N=1: always zero
    configure(1);
    cnt = 0;
    repeat (20) begin
      step(0, 0, 1, $urandom, 1);
      if (out_valid) begin cnt++; chk("n1_data", out_data, 0); end
    end
    chk("n1_valid_cycles", cnt > 0, 1);

    // Full buffer drops, then in-order drain
    configure(16);
    for (int i = 0; i < 6; i++) step(0, 0, 1, {$urandom_range(0, 65535), words[i]}, 0);
    step(0, 0, 0, 0, 0);
    chk("full_valid", out_valid, 1);
`ifdef RANGE_SAMPLER_STATS_EN
    chk("full_drops", drop_count, 2);
`endif
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", out_data, {16'd0, words[i]});
      step(0, 0, 0, 0, 1);
    end
    chk("drain_empty", out_valid, 0);

    // N=0 in RUN keeps the old bound; N=5 flushes
    configure(10);
    for (int i = 1; i <= 3; i++) step(0, 0, 1, i, 0);
    step(1, 0, 0, 0, 0);
    chk("n0_cfg_err", cfg_err, 1);
    chk("n0_busy", busy, 0);
    chk("n0_head", out_data, 1);
    step(0, 0, 1, 32'h0000_0004, 0);
    chk("n0_err_pulse", cfg_err, 0);
    chk("n0_state", state_dbg, RUN);
    step(1, 5, 0, 0, 0);
    chk("n5_busy", busy, 1);
    chk("n5_flushed", out_valid, 0);
    step(0, 0, 0, 0, 1);
    repeat (50) begin
      step(0, 0, $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
      if (out_valid) chk("n5_range", out_data < 5, 1);
    end

    // Random soak
    repeat (2000) begin
      if ($urandom_range(0, 19) == 0)
        step(1, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 40),
             $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1));
      else
        step(0, 0, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1));
    end

    // Asynchronous reset mid-RUN
    configure(10);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h0000_0002, 0);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_data", out_data, 0);
    chk("async_state", state_dbg, IDLE);
    @(negedge clk);
    rst = 0;
    repeat (10) step(0, 0, 1, $urandom, 1);
    chk("post_rst_idle", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/range_sampler.md
RANGE_SAMPLER -- requirements
Module: range_sampler

Interface
REQ-001 Parameter OUT_W, default 16: output sample width in bits, 2..32.
REQ-002 Parameter FIFO_DEPTH, default 4: output buffer entries, power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rnd_in  input  32  raw random word from the upstream taus88 generator.
REQ-006 rnd_valid  input  1  rnd_in is a fresh word this cycle (tie high for a free-running generator).
REQ-007 cfg_we  input  1  one-cycle strobe; load range_n.
REQ-008 range_n  input  OUT_W  exclusive upper bound N; samples lie in [0, N).
REQ-009 cfg_err  output  1  one-cycle pulse when cfg_we carries N=0.
REQ-010 out_valid  output  1  head of buffer holds a sample.
REQ-011 out_data  output  OUT_W  sample value; meaningful only while out_valid=1.
REQ-012 out_ready  input  1  consumer accepts out_data; transfer occurs when out_valid and out_ready are both 1.
REQ-013 busy  output  1  high in SETUP state.

Function
REQ-014 FSM states: IDLE, SETUP, RUN. IDLE->SETUP on cfg_we with N!=0. SETUP->RUN after exactly one cycle. RUN->SETUP on cfg_we with N!=0.
REQ-015 cfg_we with N=0: pulse cfg_err next cycle; state, bound and mask unchanged.
REQ-016 SETUP: register N; compute mask = smallest 2^k-1 >= N-1, with N=1 giving mask 0; flush the FIFO.
REQ-017 In RUN, each cycle with rnd_valid=1: cand = rnd_in[OUT_W-1:0] & mask; accept if cand < N, else reject; upper rnd_in bits are ignored.
REQ-018 An accepted cand is pushed to the FIFO; if FIFO is empty it appears on out_data with out_valid=1 on the next cycle (latency 1).
REQ-019 FIFO full and no pop that cycle: accepted cand is dropped; no back-pressure to upstream.
REQ-020 FIFO full with a pop in the same cycle: push and pop both occur; occupancy unchanged.
REQ-021 FIFO empty and push in the same cycle: no bypass; out_valid rises the next cycle.
REQ-022 out_data stable while out_valid=1 and out_ready=0.
REQ-023 In IDLE and SETUP, rnd_in is ignored and no pushes occur.
REQ-024 FIFO pointers wrap modulo FIFO_DEPTH; a separate count distinguishes full from empty.
REQ-025 cfg_we mid-RUN discards all buffered samples; out_valid is 0 during SETUP.

Reset
REQ-026 On rst: state=IDLE, N=0, mask=0, FIFO empty, out_valid=0, out_data=0, cfg_err=0, busy=0, counters=0; takes effect without a clock edge, including mid-RUN.
REQ-027 Release from reset does not auto-start; cfg_we is required.

Configuration
REQ-028 Macro RANGE_SAMPLER_STATS_EN defined: add outputs rej_count (32 bit) and drop_count (32 bit). Both count in RUN, saturate at all-ones, and clear on rst and on entry to SETUP.
REQ-029 Macro absent: these ports and their logic do not exist; all other behaviour is identical.

Structure
REQ-030 Shared package rng_pkg holds the FSM state typedef (IDLE/SETUP/RUN) and a mask-computation function reusable by other RNG post-processors.
REQ-031 One sub-module, sync_fifo (parameters WIDTH, DEPTH), implements the buffer; the FSM, mask and accept logic stay in range_sampler.
REQ-032 The file carries a `common/` include guard style and instantiates nothing from outside rng_pkg and sync_fifo.

Verification
REQ-033 Config N=10 (mask 0xF), out_ready=1; rnd_in low bits 0x0003 -> out_data=3 one cycle later; 0x000C -> rejected, no out_valid, rej_count +1.
REQ-034 N=16: 1000 random words -> zero rejects, every value 0..15 observed, none >=16.
REQ-035 N=1: any rnd_in -> out_data=0 every valid cycle.
REQ-036 FIFO_DEPTH=4, out_ready=0, 6 accepted words -> out_valid=1 with 4 entries held; 2 dropped (drop_count=2); then out_ready=1 -> first 4 accepted values drained in order.
REQ-037 cfg_we N=0 in RUN -> cfg_err pulse, sampling continues with the old N; cfg_we N=5 with 3 buffered -> busy one cycle, FIFO empty, new samples <5.
REQ-038 Assert rst mid-RUN between clock edges -> out_valid=0 and state IDLE immediately; after release, no samples until cfg_we.
